// File: rtl/gemm_pkg.sv
// gemm_pkg -- shared definitions for the GEMM engine.
//   state_t      : FSM state encoding (IDLE, RUN)
//   DEF_N        : default matrix dimension
//   DEF_IN_W     : default operand element width
//   DEF_ACC_W    : default accumulator / result element width
package gemm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_N     = 2;
  localparam int DEF_IN_W  = 8;
  localparam int DEF_ACC_W = 32;

endpackage

// File: rtl/gemm_engine_if.sv
// gemm_engine_if -- request/result bundle of the GEMM engine.
//   start  : operation request (master -> slave)
//   sgn    : 1 = signed operands, 0 = unsigned (master -> slave)
//   a_mat  : matrix A, row-major, N*N*IN_W bits (master -> slave)
//   b_mat  : matrix B, same packing (master -> slave)
//   busy   : operation in progress (slave -> master)
//   done   : one-cycle completion pulse (slave -> master)
//   ovf    : sticky accumulation overflow (slave -> master)
//   c_mat  : result C = A x B, N*N*ACC_W bits (slave -> master)
interface gemm_engine_if #(
  parameter int N     = 2,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
);
  logic                    start;
  logic                    sgn;
  logic [N*N*IN_W-1:0]     a_mat;
  logic [N*N*IN_W-1:0]     b_mat;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic [N*N*ACC_W-1:0]    c_mat;

  modport master (
    output start, sgn, a_mat, b_mat,
    input  busy, done, ovf, c_mat
  );

  modport slave (
    input  start, sgn, a_mat, b_mat,
    output busy, done, ovf, c_mat
  );
endinterface

// File: rtl/gemm_mac.sv
// gemm_mac -- combinational multiply-accumulate step.
//   sgn_i  : 1 = signed two's-complement operands / accumulator
//   a_i    : operand A element
//   b_i    : operand B element
//   acc_i  : current accumulator
//   sum_o  : acc_i + a_i*b_i (wrapped, or clamped when GEMM_SAT_EN)
//   ovf_o  : the accumulation left the representable range
// Build option: define GEMM_SAT_EN to clamp overflowing sums.
module gemm_mac import gemm_pkg::*; #(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             sgn_i,
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  b_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] a_x;
  logic [ACC_W-1:0] b_x;
  logic [ACC_W-1:0] prod;
  logic [ACC_W:0]   sum_x;

  // Operands are extended straight to ACC_W. The exact product always fits
  // in 2*IN_W bits, so the low ACC_W bits of this product equal the 2*IN_W
  // product sign/zero-extended to ACC_W.
  assign a_x  = {{(ACC_W-IN_W){sgn_i & a_i[IN_W-1]}}, a_i};
  assign b_x  = {{(ACC_W-IN_W){sgn_i & b_i[IN_W-1]}}, b_i};
  assign prod = a_x * b_x;

  // One guard bit: exact signed sum in signed mode, carry out in unsigned.
  assign sum_x = {sgn_i & acc_i[ACC_W-1], acc_i} + {sgn_i & prod[ACC_W-1], prod};
  assign ovf_o = sgn_i ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];

`ifdef GEMM_SAT_EN
  // Signed overflow needs both addends of the same sign, so the product's
  // sign tells which rail to clamp to.
  always_comb begin
    sum_o = sum_x[ACC_W-1:0];
    if (ovf_o) begin
      if (!sgn_i) begin
        sum_o = '1;
      end else if (prod[ACC_W-1]) begin
        sum_o = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum_o = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end
`else
  assign sum_o = sum_x[ACC_W-1:0];
`endif

endmodule

// File: rtl/gemm_engine.sv
// gemm_engine -- sequential NxN matrix multiplier, one MAC per cycle.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : gemm_engine_if.slave (start, sgn, a_mat, b_mat in;
//            busy, done, ovf, c_mat out)
// Operands are latched on an accepted start; the run takes N^3 cycles,
// iterating k innermost, then j, then i. Build option GEMM_SAT_EN makes
// overflowing accumulations saturate instead of wrap.
module gemm_engine import gemm_pkg::*; #(
  parameter int N     = DEF_N,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  gemm_engine_if.slave bus
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state_q, state_d;

  logic [IN_W-1:0]  a_in [N][N];
  logic [IN_W-1:0]  b_in [N][N];
  logic [IN_W-1:0]  a_q  [N][N];
  logic [IN_W-1:0]  b_q  [N][N];
  logic [ACC_W-1:0] c_q  [N][N];
  logic [N*N*ACC_W-1:0] c_flat;

  logic             sgn_q;
  logic [IW-1:0]    i_q, j_q, k_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             done_q;

  logic [ACC_W-1:0] mac_sum;
  logic             mac_ovf;
  logic             accept;
  logic             last_k;
  logic             last_mac;

  // Unpack the row-major operand buses into 2-D arrays.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_in[gi][gj] = bus.a_mat[(gi*N+gj)*IN_W +: IN_W];
      assign b_in[gi][gj] = bus.b_mat[(gi*N+gj)*IN_W +: IN_W];
    end
  end

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_k   = (k_q == LAST);
  assign last_mac = last_k && (j_q == LAST) && (i_q == LAST);

  gemm_mac #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .sgn_i (sgn_q),
    .a_i   (a_q[i_q][k_q]),
    .b_i   (b_q[k_q][j_q]),
    .acc_i (acc_q),
    .sum_o (mac_sum),
    .ovf_o (mac_ovf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_mac)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      c_q     <= '{default: '0};
      sgn_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        sgn_q <= bus.sgn;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == RUN) begin
        if (mac_ovf) ovf_q <= 1'b1;
        if (last_k) begin
          // Dot product complete: publish it and restart the accumulator.
          c_q[i_q][j_q] <= mac_sum;
          acc_q         <= '0;
          k_q           <= '0;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end else begin
          acc_q <= mac_sum;
          k_q   <= k_q + 1'b1;
        end
        if (last_mac) done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    c_flat = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        c_flat[(r*N+c)*ACC_W +: ACC_W] = c_q[r][c];
      end
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
  assign bus.c_mat = c_flat;

endmodule

// File: tb/tb_gemm_engine.sv
// tb_gemm_engine -- self-checking bench for gemm_engine.
// Three instances: N=2/ACC_W=32, N=2/ACC_W=16, N=4/ACC_W=32.
// Results are compared against a dot-product model that applies the
// wrap/saturate rule after every accumulation (GEMM_SAT_EN aware).
module tb_gemm_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gemm_engine_if #(.N(2), .IN_W(8), .ACC_W(32)) ifc0 ();
  gemm_engine_if #(.N(2), .IN_W(8), .ACC_W(16)) ifc1 ();
  gemm_engine_if #(.N(4), .IN_W(8), .ACC_W(32)) ifc2 ();

  gemm_engine #(.N(2), .IN_W(8), .ACC_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
  gemm_engine #(.N(2), .IN_W(8), .ACC_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
  gemm_engine #(.N(4), .IN_W(8), .ACC_W(32)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));

  int errors = 0;
  int checks = 0;
  int sel = 0;

  logic         busy_s, done_s, ovf_s;
  logic [511:0] c_s;

  always_comb begin
    case (sel)
      1: begin
        busy_s = ifc1.busy; done_s = ifc1.done; ovf_s = ifc1.ovf;
        c_s = {448'b0, ifc1.c_mat};
      end
      2: begin
        busy_s = ifc2.busy; done_s = ifc2.done; ovf_s = ifc2.ovf;
        c_s = ifc2.c_mat;
      end
      default: begin
        busy_s = ifc0.busy; done_s = ifc0.done; ovf_s = ifc0.ovf;
        c_s = {448'b0, ifc0.c_mat};
      end
    endcase
  end

  function automatic int dut_n(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic int dut_w(input int d);
    return (d == 1) ? 16 : 32;
  endfunction

  function automatic longint elem(input logic [127:0] m, input int idx, input bit s);
    logic [7:0] v;
    v = m[idx*8 +: 8];
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // C = A x B with the range rule applied after each accumulation.
  function automatic void model(input int n, input int w, input bit s,
                                input logic [127:0] a, input logic [127:0] b,
                                output longint c[16], output bit ov);
    longint mx, mn, span, acc;
    span = longint'(1) << w;
    mx = s ? (span / 2) - 1 : span - 1;
    mn = s ? -(span / 2) : 0;
    ov = 1'b0;
    for (int e = 0; e < 16; e++) c[e] = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++) begin
          acc = acc + elem(a, i*n+k, s) * elem(b, k*n+j, s);
          if (acc > mx || acc < mn) begin
            ov = 1'b1;
`ifdef GEMM_SAT_EN
            acc = (acc > mx) ? mx : mn;
`else
            acc = (acc > mx) ? acc - span : acc + span;
`endif
          end
        end
        c[i*n+j] = acc;
      end
    end
  endfunction

  function automatic logic [127:0] pack2(input int e00, input int e01, input int e10, input int e11);
    return {96'b0, 8'(e11), 8'(e10), 8'(e01), 8'(e00)};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit st, input bit s,
                       input logic [127:0] a, input logic [127:0] b);
    case (d)
      1: begin ifc1.start = st; ifc1.sgn = s; ifc1.a_mat = a[31:0]; ifc1.b_mat = b[31:0]; end
      2: begin ifc2.start = st; ifc2.sgn = s; ifc2.a_mat = a;       ifc2.b_mat = b;       end
      default: begin ifc0.start = st; ifc0.sgn = s; ifc0.a_mat = a[31:0]; ifc0.b_mat = b[31:0]; end
    endcase
  endtask

  // One operation: start, scramble inputs, wait for done, check everything.
  // Returns on the cycle done is high, so a following call starts back-to-back.
  task automatic run_op(input int d, input bit s, input logic [127:0] a,
                        input logic [127:0] b, input bit disturb, input string name);
    longint       ec[16];
    bit           eov;
    int           n, w, cnt;
    longint       mask, got, exp;
    logic [127:0] ad;
    logic [511:0] sh;
    n = dut_n(d);
    w = dut_w(d);
    mask = (longint'(1) << w) - 1;
    model(n, w, s, a, b, ec, eov);
    sel = d;
    drive(d, 1'b1, s, a, b);
    step();
    checks++;
    if (busy_s !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %0b expected 1", name, busy_s);
    end
    ad = rnd128();
    drive(d, 1'b0, ~s, ad, ~b);
    cnt = 0;
    while (cnt < 1000) begin
      step();
      cnt++;
      if (done_s === 1'b1) break;
      if (disturb && cnt == 10) drive(d, 1'b1, s, ~a, b);
      if (disturb && cnt == 11) drive(d, 1'b0, ~s, ad, rnd128());
    end
    checks++;
    if (cnt != n*n*n) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cnt, n*n*n);
    end
    checks++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %0b expected 0", name, busy_s);
    end
    for (int e = 0; e < n*n; e++) begin
      sh = c_s >> (e*w);
      got = longint'(sh[63:0]) & mask;
      exp = ec[e] & mask;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s c[%0d]: got 0x%0h expected 0x%0h", name, e, got, exp);
      end
    end
    checks++;
    if (ovf_s !== eov) begin
      errors++;
      $display("FAIL %s ovf: got %0b expected %0b", name, ovf_s, eov);
    end
    $display("op %s dut=%0d sgn=%0d latency=%0d ovf=%0b", name, d, s, cnt, ovf_s);
  endtask

  task automatic test_reset();
    ifc0.start = 0; ifc0.sgn = 0; ifc0.a_mat = '0; ifc0.b_mat = '0;
    ifc1.start = 0; ifc1.sgn = 0; ifc1.a_mat = '0; ifc1.b_mat = '0;
    ifc2.start = 0; ifc2.sgn = 0; ifc2.a_mat = '0; ifc2.b_mat = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      checks++;
      if (busy_s !== 1'b0 || done_s !== 1'b0 || ovf_s !== 1'b0 || c_s !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: got busy=%b done=%b ovf=%b c_nonzero=%b expected all 0",
                 d, busy_s, done_s, ovf_s, |c_s);
      end
    end
    $display("op reset done");
  endtask

  task automatic test_directed();
    run_op(0, 1'b1, pack2(1, 0, 0, 1), pack2(5, -3, 7, 2), 1'b0, "identity");
    step();
    checks++;
    if (done_s !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got %0b expected 0", done_s);
    end
    run_op(0, 1'b1, pack2(-2, 3, 4, -1), pack2(1, 2, 3, 4), 1'b0, "mixed_sign");
    checks++;
    if (c_s[127:0] !== {32'd4, 32'd1, 32'd8, 32'd7}) begin
      errors++;
      $display("FAIL mixed_sign_const: got 0x%0h expected C=[[7,8],[1,4]]", c_s[127:0]);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [15:0] eu, es;
`ifdef GEMM_SAT_EN
    eu = 16'd65535; es = 16'h7FFF;
`else
    eu = 16'd64514; es = 16'h8000;
`endif
    run_op(1, 1'b0, 128'hFFFF_FFFF, 128'hFFFF_FFFF, 1'b0, "ovf_unsigned");
    checks++;
    if (c_s[15:0] !== eu || c_s[63:48] !== eu || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_unsigned_const: got c0=%0d c3=%0d ovf=%b expected %0d ovf=1",
               c_s[15:0], c_s[63:48], ovf_s, eu);
    end
    step();
    run_op(1, 1'b1, 128'h8080_8080, 128'h8080_8080, 1'b0, "ovf_signed");
    checks++;
    if (c_s[15:0] !== es || c_s[47:32] !== es || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_signed_const: got c0=0x%0h c2=0x%0h ovf=%b expected 0x%0h ovf=1",
               c_s[15:0], c_s[47:32], ovf_s, es);
    end
    step();
  endtask

  // Consecutive calls start on the done cycle of the previous operation.
  task automatic test_back_to_back();
    for (int it = 0; it < 10; it++) begin
      run_op(it % 2, 1'($urandom), rnd128(), rnd128(), 1'b0, "b2b_random");
    end
    step();
  endtask

  task automatic test_n4_ignore();
    run_op(2, 1'b1, rnd128(), rnd128(), 1'b1, "n4_signed_disturb");
    run_op(2, 1'b0, rnd128(), rnd128(), 1'b1, "n4_unsigned_disturb");
    step();
  endtask

  task automatic test_reset_midrun();
    bit seen;
    sel = 2;
    drive(2, 1'b1, 1'b1, rnd128(), rnd128());
    step();
    drive(2, 1'b0, 1'b1, rnd128(), rnd128());
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || c_s !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b c_nonzero=%b expected 0,0,0",
               busy_s, done_s, |c_s);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      step();
      if (done_s === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: got done seen=%b expected 0", seen);
    end
    $display("op midrun_reset dut=2");
    run_op(2, 1'b1, rnd128(), rnd128(), 1'b0, "after_reset");
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_back_to_back();
    test_n4_ignore();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
